// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: serial line in, committed word plus status out.
// valid is a one-cycle strobe with no ready; data_rx and both flags are stable from that cycle until the next strobe.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 din;
  logic [DATA_BITS-1:0] data_rx;
  logic                 valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  logic [2:0]           state_dbg;

  modport master (
    output din,
    input  data_rx, valid, parity_err, frame_err, busy, state_dbg
  );

  modport slave (
    input  din,
    output data_rx, valid, parity_err, frame_err, busy, state_dbg
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with parity, 1/2 stop bits and error flags.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit (adds one cycle of latency).
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 279,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_param_if.slave rx
);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMPLE_AT = MID + 1;
`else
  localparam int SAMPLE_AT = MID;
`endif
  localparam logic [CW-1:0] SAMPLE_CNT = CW'(SAMPLE_AT);
  localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP  = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    RECOVER = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_acc;
  logic                 parity_bad;
  logic                 bit_val;
  logic                 at_sample;
  logic                 at_last;
  logic                 cnt_clr;
  logic                 idx_clr;
  logic                 idx_inc;
  logic                 commit;

`ifdef UART_RX_MAJORITY_EN
  // hist holds din from the two cycles before the decision cycle
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx.din};
  end

  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx.din) | (hist[0] & rx.din);
`else
  assign bit_val = rx.din;
`endif

  assign at_sample    = (cnt == SAMPLE_CNT);
  assign at_last      = (cnt == LAST_CNT);
  assign rx.busy      = (state != IDLE);
  assign rx.state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_clr = at_last;
    idx_clr = 1'b0;
    idx_inc = 1'b0;
    commit  = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx.din) state_n = START;
      end
      START: begin
        if (at_sample && bit_val) begin
          state_n = IDLE;
          cnt_clr = 1'b1;
        end else if (at_last) begin
          state_n = DATA;
          idx_clr = 1'b1;
        end
      end
      DATA: begin
        if (at_last) begin
          if (idx == LAST_DATA) begin
            state_n = (PARITY_MODE != 0) ? PARITY : STOP;
            idx_clr = 1'b1;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_last) state_n = STOP;
      end
      STOP: begin
        // Commit at mid of the last stop bit so the next start edge is never missed
        if (at_sample && (idx == LAST_STOP)) begin
          commit  = 1'b1;
          cnt_clr = 1'b1;
          idx_clr = 1'b1;
          state_n = (frame_acc || !bit_val) ? RECOVER : IDLE;
        end else if (at_last) begin
          idx_inc = 1'b1;
        end
      end
      RECOVER: begin
        cnt_clr = 1'b1;
        if (rx.din) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      idx           <= '0;
      shift         <= '0;
      frame_acc     <= 1'b0;
      parity_bad    <= 1'b0;
      rx.data_rx    <= '0;
      rx.valid      <= 1'b0;
      rx.parity_err <= 1'b0;
      rx.frame_err  <= 1'b0;
    end else begin
      cnt      <= cnt_clr ? '0 : cnt + 1'b1;
      rx.valid <= commit;
      if (idx_clr)      idx <= '0;
      else if (idx_inc) idx <= idx + 1'b1;
      if (state == IDLE) begin
        frame_acc  <= 1'b0;
        parity_bad <= 1'b0;
      end
      if (at_sample) begin
        if (state == DATA) shift[idx] <= bit_val;
        // Even parity wants an even total count of ones, odd wants odd
        if (state == PARITY) parity_bad <= (PARITY_MODE == 1) ? (^shift ^ bit_val) : ~(^shift ^ bit_val);
        if ((state == STOP) && !bit_val) frame_acc <= 1'b1;
      end
      if (commit) begin
        rx.data_rx    <= shift;
        rx.parity_err <= parity_bad;
        rx.frame_err  <= frame_acc | ~bit_val;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: 8N1 (P=279), 8E1 (P=16) and 7O2 (P=16) receivers on shared clock/reset.
module tb_uart_rx_param;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int P0 = 279;
  localparam int P1 = 16;
  localparam int MID0 = 139;
  // 279*9+139+1 = 2651; 16*10+8+1 = 169 for both 8E1 and 7O2
  localparam int LAT0 = 2651 + MAJ;
  localparam int LAT1 = 169 + MAJ;
  localparam int LAT2 = 169 + MAJ;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  logic [42:0] exp_q0[$];
  logic [42:0] exp_q1[$];
  logic [42:0] exp_q2[$];
  logic [42:0] e_m0, e_m1, e_m2;

  uart_rx_param_if #(.DATA_BITS(8)) rx0 ();
  uart_rx_param_if #(.DATA_BITS(8)) rx1 ();
  uart_rx_param_if #(.DATA_BITS(7)) rx2 ();

  uart_rx_param #(.CLKS_PER_BIT(P0), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0.slave)
  );
  uart_rx_param #(.CLKS_PER_BIT(P1), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1.slave)
  );
  uart_rx_param #(.CLKS_PER_BIT(P1), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_din(input int dut, input logic v);
    case (dut)
      0:       rx0.din = v;
      1:       rx1.din = v;
      default: rx2.din = v;
    endcase
  endtask

  // Caller is at a negedge; the next posedge is E0. Bits go LSB first, start bit in line[0].
  task automatic send_frame(input int dut, input logic [15:0] line, input int nbits,
                            input int glitch_at, input bit push,
                            input logic [8:0] edata, input logic epe, input logic efe);
    int p;
    int lat;
    int e0;
    int k;
    p   = (dut == 0) ? P0 : P1;
    lat = (dut == 0) ? LAT0 : ((dut == 1) ? LAT1 : LAT2);
    e0  = cyc + 1;
    if (push) begin
      case (dut)
        0:       exp_q0.push_back({32'(e0 + lat), edata, epe, efe});
        1:       exp_q1.push_back({32'(e0 + lat), edata, epe, efe});
        default: exp_q2.push_back({32'(e0 + lat), edata, epe, efe});
      endcase
    end
    k = 0;
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < p; c++) begin
        set_din(dut, line[i] ^ (k == glitch_at));
        @(negedge clk);
        k++;
      end
    end
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rx0.valid) begin
      if (exp_q0.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u0_unexpected_valid: got valid data %0h, required no valid (cycle %0d)", rx0.data_rx, cyc);
      end else begin
        e_m0 = exp_q0.pop_front();
        check("u0_valid_cycle", cyc, e_m0[42:11]);
        check("u0_data", 32'(rx0.data_rx), 32'(e_m0[10:2]));
        check("u0_parity_err", 32'(rx0.parity_err), 32'(e_m0[1]));
        check("u0_frame_err", 32'(rx0.frame_err), 32'(e_m0[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rx1.valid) begin
      if (exp_q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u1_unexpected_valid: got valid data %0h, required no valid (cycle %0d)", rx1.data_rx, cyc);
      end else begin
        e_m1 = exp_q1.pop_front();
        check("u1_valid_cycle", cyc, e_m1[42:11]);
        check("u1_data", 32'(rx1.data_rx), 32'(e_m1[10:2]));
        check("u1_parity_err", 32'(rx1.parity_err), 32'(e_m1[1]));
        check("u1_frame_err", 32'(rx1.frame_err), 32'(e_m1[0]));
      end
    end
  end

  always @(negedge clk) begin
    if (rx2.valid) begin
      if (exp_q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL u2_unexpected_valid: got valid data %0h, required no valid (cycle %0d)", rx2.data_rx, cyc);
      end else begin
        e_m2 = exp_q2.pop_front();
        check("u2_valid_cycle", cyc, e_m2[42:11]);
        check("u2_data", 32'(rx2.data_rx), 32'(e_m2[10:2]));
        check("u2_parity_err", 32'(rx2.parity_err), 32'(e_m2[1]));
        check("u2_frame_err", 32'(rx2.frame_err), 32'(e_m2[0]));
      end
    end
  end

  initial begin
    #(3_000_000);
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rx0.din = 1'b1;
    rx1.din = 1'b1;
    rx2.din = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_rx", 32'(rx0.data_rx), 32'h0);
    check("reset_valid", 32'(rx0.valid), 32'h0);
    check("reset_parity_err", 32'(rx0.parity_err), 32'h0);
    check("reset_frame_err", 32'(rx0.frame_err), 32'h0);
    check("reset_busy", 32'(rx0.busy), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5
    send_frame(0, {6'h3f, 1'b1, 8'hA5, 1'b0}, 10, -1, 1'b1, 9'h0A5, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

    // short start pulse is rejected
    rx0.din = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy_high", 32'(rx0.busy), 32'h1);
    repeat (40) @(negedge clk);
    rx0.din = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_busy_low", 32'(rx0.busy), 32'h0);

    // 0x3C with stop bit low, line held low afterwards
    send_frame(0, {6'h00, 1'b0, 8'h3C, 1'b0}, 10, -1, 1'b1, 9'h03C, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    check("recover_busy", 32'(rx0.busy), 32'h1);
    check("recover_state", 32'(rx0.state_dbg), 32'h5);
    rx0.din = 1'b1;
    repeat (3) @(negedge clk);
    check("recover_exit_busy", 32'(rx0.busy), 32'h0);
    send_frame(0, {6'h3f, 1'b1, 8'h55, 1'b0}, 10, -1, 1'b1, 9'h055, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // reset in the middle of the data bits
    send_frame(0, {12'hfff, 4'b0110}, 4, -1, 1'b0, 9'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_data_rx", 32'(rx0.data_rx), 32'h0);
    check("midreset_valid", 32'(rx0.valid), 32'h0);
    check("midreset_frame_err", 32'(rx0.frame_err), 32'h0);
    check("midreset_busy", 32'(rx0.busy), 32'h0);
    rx0.din = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(0, {6'h3f, 1'b1, 8'h99, 1'b0}, 10, -1, 1'b1, 9'h099, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // one-cycle high glitch at mid of data bit 0 of 0x00
    send_frame(0, {6'h3f, 1'b1, 8'h00, 1'b0}, 10, P0 + MID0 + 1, 1'b1,
               (MAJ != 0) ? 9'h000 : 9'h001, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // 8E1 0x07: parity bit 0 is wrong, 1 is right
    send_frame(1, {5'h1f, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 1'b1, 9'h007, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    send_frame(1, {5'h1f, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 1'b1, 9'h007, 1'b0, 1'b0);
    repeat (5) @(negedge clk);

    // 7O2 0x41 twice back to back, odd parity bit = 1
    send_frame(2, {5'h1f, 2'b11, 1'b1, 7'h41, 1'b0}, 11, -1, 1'b1, 9'h041, 1'b0, 1'b0);
    send_frame(2, {5'h1f, 2'b11, 1'b1, 7'h41, 1'b0}, 11, -1, 1'b1, 9'h041, 1'b0, 1'b0);
    repeat (20) @(negedge clk);

    check("u0_queue_drained", 32'(exp_q0.size()), 32'h0);
    check("u1_queue_drained", 32'(exp_q1.size()), 32'h0);
    check("u2_queue_drained", 32'(exp_q2.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
